// File: rtl/led_pkg.sv
// Shared definitions for the LED output stages: envelope state encoding and
// default PWM width / fade step length.
package led_pkg;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_RISE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_FALL = 2'd3;

    typedef enum logic [1:0] {
        OFF  = ST_OFF,
        RISE = ST_RISE,
        ON   = ST_ON,
        FALL = ST_FALL
    } led_state_t;

    localparam int          LED_PWM_W       = 8;
    localparam logic [23:0] LED_STEP_CYCLES = 24'd31_250;

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM generator: compares a wrapping counter against the duty
// value and registers the LED drive.
module led_pwm_core
    import led_pkg::*;
#(
    parameter int PWM_W = LED_PWM_W
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [PWM_W-1:0] Duty,
    output logic             LED_Out
);

    localparam logic [PWM_W-1:0] CNT_ONE  = 1;
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + CNT_ONE;
        end
    end

    // Full-scale duty is forced high so the LED has no dark cycle at pwm_cnt = max.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            LED_Out <= 1'b0;
        end else begin
            LED_Out <= (pwm_cnt < Duty) || (Duty == DUTY_MAX);
        end
    end

endmodule

// File: rtl/led_breath_module.sv
// LED breathing stage: turns the on/off window from the blink generator into
// linear PWM fade-in / fade-out ramps on the LED pin.
module led_breath_module
    import led_pkg::*;
#(
    parameter int          PWM_W       = LED_PWM_W,
    parameter logic [23:0] STEP_CYCLES = LED_STEP_CYCLES
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             LED_In,
    output logic             LED_Out,
    output logic             Ramp_Busy,
    output logic [PWM_W-1:0] Duty
);

    localparam logic [PWM_W-1:0] DUTY_ONE = 1;
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic             rIn;
    led_state_t       state;
    led_state_t       state_nxt;
    logic [PWM_W-1:0] duty_nxt;
    logic [23:0]      step_cnt;
    logic             tick;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rIn <= 1'b0;
        end else begin
            rIn <= LED_In;
        end
    end

    assign Ramp_Busy = (state == RISE) || (state == FALL);
    assign tick      = Ramp_Busy && (step_cnt == STEP_CYCLES - 24'd1);

    // Timer only runs while ramping and restarts on every state change so a
    // reversal always waits a full step before the first duty change.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            step_cnt <= '0;
        end else if (!Ramp_Busy || tick || (state_nxt != state)) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 24'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= OFF;
            Duty  <= '0;
        end else begin
            state <= state_nxt;
            Duty  <= duty_nxt;
        end
    end

    // A window reversal takes priority over a pending step; duty saturates at both ends.
    always_comb begin
        state_nxt = state;
        duty_nxt  = Duty;
        case (state)
            OFF: begin
                duty_nxt = '0;
                if (rIn) begin
                    state_nxt = RISE;
                end
            end
            RISE: begin
                if (!rIn) begin
                    state_nxt = FALL;
                end else if (tick) begin
                    if (Duty != DUTY_MAX) begin
                        duty_nxt = Duty + DUTY_ONE;
                    end
                    if (Duty >= DUTY_MAX - DUTY_ONE) begin
                        state_nxt = ON;
                    end
                end
            end
            ON: begin
                duty_nxt = DUTY_MAX;
                if (!rIn) begin
                    state_nxt = FALL;
                end
            end
            FALL: begin
                if (rIn) begin
                    state_nxt = RISE;
                end else if (tick) begin
                    if (Duty != '0) begin
                        duty_nxt = Duty - DUTY_ONE;
                    end
                    if (Duty <= DUTY_ONE) begin
                        state_nxt = OFF;
                    end
                end
            end
            default: begin
                state_nxt = OFF;
                duty_nxt  = '0;
            end
        endcase
    end

    led_pwm_core #(
        .PWM_W (PWM_W)
    ) u_pwm_core (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .Duty    (Duty),
        .LED_Out (LED_Out)
    );

endmodule

// File: tb/tb_led_breath_module.sv
// Self-checking bench for led_breath_module: constant vector table, hand-written
// fade/reversal/reset sequences, random windows against a behavioural model.
module tb_led_breath_module;

    localparam int STEP = 4;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       LED_In = 1'b0;
    logic       LED_Out;
    logic       Ramp_Busy;
    logic [7:0] Duty;

    logic       LED_In2 = 1'b0;
    logic       LED_Out2;
    logic       Ramp_Busy2;
    logic [7:0] Duty2;

    int tests = 0;
    int failed = 0;
    int edgeIdx = 0;

    // Behavioural model: duty level, ramp direction (+1/-1/0) and cycles spent in that direction.
    int mRin, mDuty, mDir, mElapsed, mPwm;
    int mLed;

    led_breath_module #(.PWM_W(8), .STEP_CYCLES(24'd4)) dut (
        .CLK(CLK), .RSTn(RSTn), .LED_In(LED_In),
        .LED_Out(LED_Out), .Ramp_Busy(Ramp_Busy), .Duty(Duty)
    );

    led_breath_module #(.PWM_W(8), .STEP_CYCLES(24'd256)) dut2 (
        .CLK(CLK), .RSTn(RSTn), .LED_In(LED_In2),
        .LED_Out(LED_Out2), .Ramp_Busy(Ramp_Busy2), .Duty(Duty2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       inBit;
        logic       busy;
        logic [7:0] duty;
        logic       led;
    } vec_t;

    vec_t vecs[15];

    task automatic checkVal(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mRin = 0; mDuty = 0; mDir = 0; mElapsed = 0; mPwm = 0; mLed = 0;
    endtask

    task automatic modelStep();
        int want;
        int newLed;
        newLed = ((mPwm < mDuty) || (mDuty == 255)) ? 1 : 0;
        mPwm = (mPwm + 1) % 256;
        if (mDir == 0) begin
            if (mRin == 1 && mDuty == 0) begin
                mDir = 1; mElapsed = 0;
            end else if (mRin == 0 && mDuty == 255) begin
                mDir = -1; mElapsed = 0;
            end
        end else begin
            want = (mRin == 1) ? 1 : -1;
            if (want != mDir) begin
                mDir = want; mElapsed = 0;
            end else begin
                mElapsed++;
                if (mElapsed == STEP) begin
                    mElapsed = 0;
                    mDuty = mDuty + mDir;
                    if (mDuty > 255) mDuty = 255;
                    if (mDuty < 0) mDuty = 0;
                    if ((mDir > 0 && mDuty == 255) || (mDir < 0 && mDuty == 0)) mDir = 0;
                end
            end
        end
        mRin = LED_In ? 1 : 0;
        mLed = newLed;
    endtask

    task automatic applyStimulus(input logic inBit);
        LED_In = inBit;
        @(posedge CLK);
        edgeIdx++;
        modelStep();
        #1;
    endtask

    task automatic checkOutput();
        checkVal("led_out", int'(LED_Out), mLed);
        checkVal("ramp_busy", int'(Ramp_Busy), (mDir != 0) ? 1 : 0);
        checkVal("duty", int'(Duty), mDuty);
    endtask

    task automatic doReset();
        RSTn = 1'b0;
        LED_In = 1'b0;
        LED_In2 = 1'b0;
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        edgeIdx = 0;
    endtask

    initial begin
        int n;
        int highCnt;
        logic lvl;
        int len;

        // Per-edge stimulus: rise, reversal landing on a step tick, fall back to OFF.
        vecs[0]  = '{1'b1, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'd0, 1'b0};

        modelReset();
        #3;
        checkVal("reset_led_out", int'(LED_Out), 0);
        checkVal("reset_duty", int'(Duty), 0);
        checkVal("reset_busy", int'(Ramp_Busy), 0);
        doReset();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].inBit);
            checkVal($sformatf("vec%0d_busy", i), int'(Ramp_Busy), int'(vecs[i].busy));
            checkVal($sformatf("vec%0d_duty", i), int'(Duty), int'(vecs[i].duty));
            checkVal($sformatf("vec%0d_led", i), int'(LED_Out), int'(vecs[i].led));
        end

        $display("[TB] fade in");
        for (n = 1; n <= 1322; n++) begin
            applyStimulus(1'b1);
            checkOutput();
            if (n == 1) checkVal("fadein_busy_k1", int'(Ramp_Busy), 0);
            if (n == 2) checkVal("fadein_busy_k2", int'(Ramp_Busy), 1);
            if (n == 5) checkVal("fadein_duty_k5", int'(Duty), 0);
            if (n == 6) checkVal("fadein_duty_k6", int'(Duty), 1);
            if (n == 1021) checkVal("fadein_duty_k1021", int'(Duty), 254);
            if (n == 1022) begin
                checkVal("fadein_duty_k1022", int'(Duty), 255);
                checkVal("fadein_busy_k1022", int'(Ramp_Busy), 0);
            end
            if (n >= 1023) checkVal("fadein_led_on", int'(LED_Out), 1);
        end

        $display("[TB] fade out");
        for (n = 1; n <= 1322; n++) begin
            applyStimulus(1'b0);
            checkOutput();
            if (n == 2) checkVal("fadeout_busy_k2", int'(Ramp_Busy), 1);
            if (n == 5) checkVal("fadeout_duty_k5", int'(Duty), 255);
            if (n == 6) checkVal("fadeout_duty_k6", int'(Duty), 254);
            if (n == 1021) checkVal("fadeout_duty_k1021", int'(Duty), 1);
            if (n == 1022) begin
                checkVal("fadeout_duty_k1022", int'(Duty), 0);
                checkVal("fadeout_busy_k1022", int'(Ramp_Busy), 0);
            end
            if (n >= 1023) checkVal("fadeout_led_off", int'(LED_Out), 0);
        end

        $display("[TB] reversal at duty 100");
        n = 0;
        while (mDuty != 100 && n < 1000) begin
            applyStimulus(1'b1);
            checkOutput();
            n++;
        end
        checkVal("rev_reach_100", mDuty, 100);
        applyStimulus(1'b0);
        checkOutput();
        applyStimulus(1'b0);
        checkOutput();
        checkVal("rev_fall_busy", int'(Ramp_Busy), 1);
        checkVal("rev_fall_duty", int'(Duty), 100);
        repeat (3) begin
            applyStimulus(1'b0);
            checkOutput();
        end
        checkVal("rev_hold_duty", int'(Duty), 100);
        applyStimulus(1'b0);
        checkOutput();
        checkVal("rev_first_dec", int'(Duty), 99);

        $display("[TB] reset mid-rise");
        doReset();
        n = 0;
        while (mDuty != 37 && n < 500) begin
            applyStimulus(1'b1);
            checkOutput();
            n++;
        end
        checkVal("rst_pre_duty", int'(Duty), 37);
        checkVal("rst_pre_busy", int'(Ramp_Busy), 1);
        RSTn = 1'b0;
        #1;
        checkVal("rst_async_led", int'(LED_Out), 0);
        checkVal("rst_async_duty", int'(Duty), 0);
        checkVal("rst_async_busy", int'(Ramp_Busy), 0);
        doReset();
        for (n = 0; n < 20; n++) begin
            applyStimulus(1'b0);
            checkOutput();
            checkVal("rst_stay_off", int'(Ramp_Busy), 0);
        end

        $display("[TB] random windows");
        for (int s = 0; s < 30; s++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 400));
            for (int c = 0; c < len; c++) begin
                applyStimulus(lvl);
                checkOutput();
            end
        end

        $display("[TB] steady duty 64");
        doReset();
        LED_In2 = 1'b1;
        while (edgeIdx < 2 + 64 * 256) begin
            applyStimulus(1'b0);
        end
        checkVal("pwm_duty64_reached", int'(Duty2), 64);
        highCnt = 0;
        for (n = 0; n < 256; n++) begin
            applyStimulus(1'b0);
            if (LED_Out2) highCnt++;
            checkVal("pwm_phase", int'(LED_Out2), (((edgeIdx - 1) % 256) < 64) ? 1 : 0);
        end
        checkVal("pwm_high_count", highCnt, 64);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/led_breath_module.md
# led_breath_module

Downstream LED output stage: takes the registered on/off window produced by a blink generator such as `led2_module` and drives the physical LED with a PWM brightness envelope. A rising window fades the LED in, a falling window fades it out, and hard edges become linear ramps. The block sits between the pattern/blink generator and the board LED pin.

## Interface
- `PWM_W`, default 8: PWM counter and duty width, in bits.
- `STEP_CYCLES`, default 24'd31_250: clock cycles per one-LSB duty step (full ramp = 255 × STEP_CYCLES).
- `CLK`  in  1: system clock. One clock domain only.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `LED_In`  in  1: target window, same clock domain, already registered upstream. 1 = lit, 0 = dark.
- `LED_Out`  out  1: PWM-modulated LED drive, registered.
- `Ramp_Busy`  out  1: high while the envelope is ramping (RISE or FALL).
- `Duty`  out  PWM_W: current duty value, for observability.

## Operation
- `rIn`: one-stage register of `LED_In`. All decisions use `rIn`, never `LED_In` directly.
- PWM counter `pwm_cnt` (PWM_W bits):
  - free-running, wraps at 2^PWM_W−1 → 0;
  - resets to 0.
- Compare output: `LED_Out` next = (`pwm_cnt` < `Duty`) OR (`Duty` == all-ones).
  - Duty 0 → constant 0.
  - Duty all-ones → constant 1, no 1-cycle gap.
- Step timer:
  - counts 0..STEP_CYCLES−1 and raises a one-cycle `tick` at STEP_CYCLES−1, then wraps;
  - held at 0 in OFF and ON;
  - cleared to 0 on every state change.
- State machine:
  - **OFF**: Duty = 0. If `rIn`=1, go to RISE.
  - **RISE**:
    - on `tick`, Duty += 1;
    - if Duty reaches all-ones, go to ON;
    - if `rIn`=0, go to FALL immediately. Duty is kept, with no jump.
  - **ON**: Duty = all-ones. If `rIn`=0, go to FALL.
  - **FALL**:
    - on `tick`, Duty −= 1;
    - if Duty reaches 0, go to OFF;
    - if `rIn`=1, go to RISE immediately. Duty is kept.
- Simultaneous events:
  - a `rIn` reversal and a `tick` on the same cycle: the reversal wins and Duty is not stepped that cycle;
  - Duty never under- or overflows, because it saturates at the bounds.
- `Ramp_Busy` = state is RISE or FALL, decoded from the state register.
- Reset mid-ramp: all registers return to their reset values immediately (asynchronous reset). After release, the block starts from OFF.

## Timing
- Reset values: `LED_Out`=0, `Ramp_Busy`=0, `Duty`=0, state=OFF, `rIn`=0, `pwm_cnt`=0, step timer=0.
- `LED_In` change at edge k:
  - `rIn` updates at k+1;
  - state and `Ramp_Busy` update at k+2;
  - the first Duty step occurs at k+2+STEP_CYCLES.
- `Duty` change at edge m → `LED_Out` reflects the new compare at m+1.
- Full ramp OFF→ON with `LED_In` held high: RISE entered at k+2, ON entered at k+2+255×STEP_CYCLES. Duty reaches 255 and ON is entered on that same edge.
- Pulses of `LED_In` shorter than 1 cycle cannot occur (synchronous input).

## Structure
- Shared package `led_pkg`:
  - state encoding localparams (OFF=2'd0, RISE=2'd1, ON=2'd2, FALL=2'd3);
  - default `PWM_W` and `STEP_CYCLES` constants, reused by other LED stages.
- One sub-module, `led_pwm_core`:
  - contents: free-running PWM counter, compare, and the `LED_Out` register;
  - inputs: `CLK`, `RSTn`, `Duty`;
  - output: `LED_Out`.
- The top level holds `rIn`, the step timer, the FSM, and `Duty`.

## Test plan
All scenarios use `STEP_CYCLES`=4 and `PWM_W`=8 unless noted.
- **Reset**: assert `RSTn`=0 mid-RISE at Duty=37 → same cycle `LED_Out`=0, `Duty`=0, `Ramp_Busy`=0. After release, the block stays OFF with `LED_In`=0.
- **Fade in**: `LED_In` 0→1 at edge k, held high → `Ramp_Busy`=1 at k+2, `Duty`=1 at k+6, `Duty`=255 and `Ramp_Busy`=0 at k+2+1020, then `LED_Out` constantly 1.
- **Fade out**: from ON, `LED_In`→0 at edge k → `Duty`=254 at k+6, `Duty`=0 with state OFF at k+1022, then `LED_Out` constantly 0.
- **Reversal mid-ramp**: drop `LED_In` while in RISE at Duty=100 → FALL is entered with Duty still 100. The first decrement comes 4 cycles after the state change, giving 99.
- **Reversal coinciding with tick**: `rIn` falls on the same cycle as `tick` → Duty unchanged that cycle and the step timer clears to 0.
- **PWM duty**: force a steady Duty=64 (`STEP_CYCLES` large) → over any 256-cycle window, `LED_Out` is high exactly 64 cycles, contiguous from `pwm_cnt`=0, delayed 1 cycle.
